// File: rtl/debounce_pkg.sv
// debounce_pkg: shared cycle constants for the 100 MHz board clock and a counter width helper
package debounce_pkg;
  localparam int DB_STABLE_5MS   = 500_000;
  localparam int DB_LONG_1S      = 100_000_000;
  localparam int DB_REPEAT_200MS = 20_000_000;
  function automatic int db_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one button's synchroniser, stability/hold counters and press/release/long/repeat strobes
// clk, reset (async, active-high); btn_i already polarity-corrected; level_o plus one-cycle strobes
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DB_STABLE_5MS,
  parameter int LONG_CYCLES   = DB_LONG_1S,
  parameter int REPEAT_CYCLES = DB_REPEAT_200MS
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o
);
  localparam int SW = db_width(STABLE_CYCLES);
  localparam int HW = db_width(LONG_CYCLES + 1);
  localparam logic [SW-1:0] S_END = SW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] L_END = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] R_END = HW'(REPEAT_CYCLES - 1);
  localparam bit REP_EN = REPEAT_CYCLES != 0;
  logic sync0_q, sync0_d, sync1_q, sync1_d, state_q, state_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [HW-1:0] hold_q, hold_d;
  logic rep_q, rep_d, press_q, press_d, rel_q, rel_d, long_q, long_d, rpt_q, rpt_d;
  logic mismatch, toggle, held;
  always_comb begin
    sync0_d  = btn_i;
    sync1_d  = sync0_q;
    mismatch = sync1_q != state_q;
    toggle   = mismatch && stab_q == S_END;
    stab_d   = (!mismatch || toggle) ? '0 : stab_q + 1'b1;
    state_d  = state_q ^ toggle;
    // held excludes the release edge so no long/repeat strobe can coincide with it
    held     = state_q && !toggle;
    long_d   = held && !rep_q && hold_q == L_END;
    rpt_d    = held && rep_q && REP_EN && hold_q == R_END;
    // reload after each strobe; with repeat disabled the counter parks at 0 once long has fired
    hold_d   = (!held || long_d || rpt_d || (rep_q && !REP_EN)) ? '0 : hold_q + 1'b1;
    rep_d    = held && (rep_q || long_d);
    press_d  = toggle && !state_q;
    rel_d    = toggle && state_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
      state_q <= 1'b0;
      stab_q  <= '0;
      hold_q  <= '0;
      rep_q   <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      rpt_q   <= 1'b0;
    end else begin
      sync0_q <= sync0_d;
      sync1_q <= sync1_d;
      state_q <= state_d;
      stab_q  <= stab_d;
      hold_q  <= hold_d;
      rep_q   <= rep_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      rpt_q   <= rpt_d;
    end
  end
  assign level_o   = state_q;
  assign press_o   = press_q;
  assign release_o = rel_q;
  assign long_o    = long_q;
  assign repeat_o  = rpt_q;
endmodule

// File: rtl/debounce_bank.sv
// debounce_bank: N independent push-button conditioners with optional active-low input inversion
// clk, reset (async, active-high); btn_i[N] raw pins; level_o, press_o, release_o, long_o, repeat_o per channel
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int N             = 4,
  parameter int STABLE_CYCLES = DB_STABLE_5MS,
  parameter int LONG_CYCLES   = DB_LONG_1S,
  parameter int REPEAT_CYCLES = DB_REPEAT_200MS,
  parameter int ACTIVE_LOW    = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] btn_i,
  output logic [N-1:0] level_o,
  output logic [N-1:0] press_o,
  output logic [N-1:0] release_o,
  output logic [N-1:0] long_o,
  output logic [N-1:0] repeat_o
);
  logic [N-1:0] btn_fix;
  assign btn_fix = (ACTIVE_LOW != 0) ? ~btn_i : btn_i;
  for (genvar i = 0; i < N; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .btn_i    (btn_fix[i]),
      .level_o  (level_o[i]),
      .press_o  (press_o[i]),
      .release_o(release_o[i]),
      .long_o   (long_o[i]),
      .repeat_o (repeat_o[i])
    );
  end
endmodule
